pl_key_debounce: RTL and testbench

- Input-side counterpart of the board's LED driver.
- Reads the PL push-buttons. Keys are active-low: pressing one drives the pin low.
- Each key goes through a 2-flop synchronizer and a per-key debounce FSM.
- Outputs a clean held level plus one-cycle press/release strobes. The PL control logic (e.g. LED pattern select) consumes these strobes instead of raw pins.

---
 rtl/pl_key_pkg.sv | 19 +
 rtl/pl_key_debounce_if.sv | 26 ++
 rtl/pl_key_filter.sv | 131 +++++++++++++
 rtl/pl_key_debounce.sv | 42 ++++
 tb/tb_pl_key_debounce.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pl_key_pkg.sv
// Shared types and helpers for the PL push-button debouncer.
package pl_key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_e;

    // Idle level of an active-low key pin: released.
    localparam logic SYNC_RST_VAL = 1'b1;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/pl_key_debounce_if.sv
// Key pin / debounced event bundle between the board pins and PL control logic.
interface pl_key_debounce_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/pl_key_filter.sv
// Single-key synchronizer + debounce FSM; optional hold counter under
// PL_KEY_LONG_PRESS_EN for the long-press strobe.
module pl_key_filter
    import pl_key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
    localparam int unsigned CNT_W    = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    if (DEB_CYC < 2 || LONG_CYC < 1) begin : g_cfg_err
        $error("pl_key_filter: DEB_CYC must be >= 2 and LONG_CYC >= 1");
    end

    logic             sync_q1;
    logic             sync_n;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             press_hit;
    logic             release_hit;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= SYNC_RST_VAL;
            sync_n  <= SYNC_RST_VAL;
        end else begin
            sync_q1 <= key_n;
            sync_n  <= sync_q1;
        end
    end

    assign press_hit   = (state == PRESS_CHK)   && !sync_n && (cnt == CNT_LAST);
    assign release_hit = (state == RELEASE_CHK) &&  sync_n && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync_n) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (sync_n) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (press_hit) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        key_press <= 1'b1;
                        key_state <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync_n) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!sync_n) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (release_hit) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_state   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PL_KEY_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold time survives release glitches; saturation gives one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (press_hit || release_hit) begin
                hold_cnt <= '0;
            end else if ((state == PRESSED || state == RELEASE_CHK) && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                key_long <= (hold_cnt == HOLD_MAX - HOLD_W'(1));
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/pl_key_debounce.sv
// PL push-button debouncer: NUM_KEYS independent filters with press/release
// strobes; long-press strobe built only with PL_KEY_LONG_PRESS_EN.
module pl_key_debounce
    import pl_key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned NUM_KEYS      = 4,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pl_key_debounce_if.slave        keys
);

    logic [NUM_KEYS-1:0] state_v;
    logic [NUM_KEYS-1:0] press_v;
    logic [NUM_KEYS-1:0] release_v;
    logic [NUM_KEYS-1:0] long_v;

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
        pl_key_filter #(
            .CLK_FREQ_HZ   (CLK_FREQ_HZ),
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS)
        ) u_filter (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n       (keys.key_n[i]),
            .key_state   (state_v[i]),
            .key_press   (press_v[i]),
            .key_release (release_v[i]),
            .key_long    (long_v[i])
        );
    end

    assign keys.key_state   = state_v;
    assign keys.key_press   = press_v;
    assign keys.key_release = release_v;
    assign keys.key_long    = long_v;

endmodule

// File: tb/tb_pl_key_debounce.sv
// Bench for pl_key_debounce: directed latency/bounce/reset steps plus random
// pin activity, checked every cycle against a stable-run-length reference.
module tb_pl_key_debounce;

    localparam int DEB  = 20;
    localparam int LONG = 100;
`ifdef PL_KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pl_key_debounce_if #(.NUM_KEYS(4)) kif ();

    pl_key_debounce #(
        .CLK_FREQ_HZ   (1000),
        .NUM_KEYS      (4),
        .DEBOUNCE_MS   (20),
        .LONG_PRESS_MS (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .keys  (kif)
    );

    // Reference: pin seen two edges late; level accepted after DEB+1 equal samples.
    logic       s1 [4];
    logic       s2 [4];
    int         run  [4];
    int         held [4];
    logic [3:0] m_state, m_press, m_rel, m_long;

    always @(posedge clk or negedge rst_n) begin
        logic samp;
        bit   tog;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                s1[k] = 1'b1; s2[k] = 1'b1; run[k] = 0; held[k] = 0;
            end
            m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
        end else begin
            m_press = '0; m_rel = '0; m_long = '0;
            for (int k = 0; k < 4; k++) begin
                samp  = s2[k];
                s2[k] = s1[k];
                s1[k] = kif.key_n[k];
                tog   = 1'b0;
                if ((!samp) != m_state[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        run[k]     = 0;
                        tog        = 1'b1;
                        m_state[k] = ~m_state[k];
                        if (m_state[k]) begin
                            m_press[k] = 1'b1;
                            held[k]    = 0;
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end
                end else begin
                    run[k] = 0;
                end
                if (LONG_EN && !tog && m_state[k]) begin
                    held[k]++;
                    if (held[k] == LONG) m_long[k] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model_state",   32'(kif.key_state),   32'(m_state));
        chk("model_press",   32'(kif.key_press),   32'(m_press));
        chk("model_release", 32'(kif.key_release), 32'(m_rel));
        chk("model_long",    32'(kif.key_long),    32'(m_long));
    endtask

    // kind: 0 press, 1 release, 2 long. n = edges until the strobe (limit if none).
    task automatic wait_evt(input int key, input int kind, input int limit, output int n);
        logic hit;
        n = 0;
        do begin
            tick();
            n++;
            case (kind)
                0:       hit = kif.key_press[key];
                1:       hit = kif.key_release[key];
                default: hit = kif.key_long[key];
            endcase
        end while (!hit && n < limit);
    endtask

    initial begin
        int n;
        int long_cnt;
        int long_first;

        // Reset state
        rst_n     = 1'b0;
        kif.key_n = 4'b1111;
        #1;
        chk("rst_state",   32'(kif.key_state),   32'h0);
        chk("rst_press",   32'(kif.key_press),   32'h0);
        chk("rst_release", 32'(kif.key_release), 32'h0);
        chk("rst_long",    32'(kif.key_long),    32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Clean press on key 0
        kif.key_n = 4'b1110;
        wait_evt(0, 0, 60, n);
        chk("clean_latency", 32'(n), 32'd23);
        chk("clean_press_vec", 32'(kif.key_press), 32'b0001);
        chk("clean_state_vec", 32'(kif.key_state), 32'b0001);
        repeat (27) tick();
        chk("clean_hold_state", 32'(kif.key_state), 32'b0001);

        // Bouncy press on key 1: 5-cycle toggles for 60 cycles
        for (int seg = 0; seg < 12; seg++) begin
            kif.key_n[1] = logic'(seg % 2);
            repeat (5) begin
                tick();
                chk("bounce_no_press", 32'(kif.key_press[1]), 32'h0);
            end
        end
        kif.key_n[1] = 1'b0;
        wait_evt(1, 0, 60, n);
        chk("bounce_latency", 32'(n), 32'd23);
        chk("bounce_state_vec", 32'(kif.key_state), 32'b0011);

        // Release glitch on key 2
        kif.key_n[2] = 1'b0;
        wait_evt(2, 0, 60, n);
        chk("glitch_press_latency", 32'(n), 32'd23);
        repeat (10) tick();
        kif.key_n[2] = 1'b1;
        repeat (10) tick();
        kif.key_n[2] = 1'b0;
        repeat (40) begin
            tick();
            chk("glitch_no_release", 32'(kif.key_release[2]), 32'h0);
            chk("glitch_state_held", 32'(kif.key_state[2]), 32'h1);
        end
        kif.key_n[2] = 1'b1;
        wait_evt(2, 1, 60, n);
        chk("release_latency", 32'(n), 32'd23);
        chk("release_state_same_cycle", 32'(kif.key_state[2]), 32'h0);
        chk("release_press_low", 32'(kif.key_press[2]), 32'h0);

        // Release everything
        kif.key_n = 4'b1111;
        repeat (30) tick();
        chk("all_released", 32'(kif.key_state), 32'h0);

        // Simultaneous press on all keys
        kif.key_n = 4'b0000;
        wait_evt(0, 0, 60, n);
        chk("simul_latency", 32'(n), 32'd23);
        chk("simul_press_vec", 32'(kif.key_press), 32'b1111);
        tick();
        chk("simul_press_gone", 32'(kif.key_press), 32'h0);
        chk("simul_state_vec", 32'(kif.key_state), 32'b1111);

        // Reset in the middle of key 0's press filter
        kif.key_n = 4'b0001;
        repeat (30) tick();
        chk("pre_reset_state", 32'(kif.key_state), 32'b1110);
        kif.key_n = 4'b0000;
        repeat (13) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_state",   32'(kif.key_state),   32'h0);
        chk("midrst_press",   32'(kif.key_press),   32'h0);
        chk("midrst_release", 32'(kif.key_release), 32'h0);
        chk("midrst_long",    32'(kif.key_long),    32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_evt(0, 0, 60, n);
        chk("post_reset_latency", 32'(n), 32'd23);
        chk("post_reset_press_vec", 32'(kif.key_press), 32'b1111);

        // Long press: keep holding for 200 cycles after the accepted press
        long_cnt   = 0;
        long_first = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (kif.key_long[0]) begin
                long_cnt++;
                if (long_first < 0) long_first = i;
            end
        end
`ifdef PL_KEY_LONG_PRESS_EN
        chk("long_pulse_count", 32'(long_cnt), 32'd1);
        chk("long_latency", 32'(long_first), 32'd100);
`else
        chk("long_pulse_count", 32'(long_cnt), 32'd0);
`endif

        // Random pin activity: long and short runs mixed
        kif.key_n = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 29) == 0) kif.key_n[k] = ~kif.key_n[k];
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
